// File: rtl/mem_scrambler.sv
// Read/scramble/write-back bus master: walks a block of memory words, bit-scrambles each
// one in place and accumulates an XOR checksum of everything it wrote.
module mem_scrambler #(
  parameter int Width = 8,  // data word width, must be even
  parameter int Depth = 5   // address width
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [Depth-1:0] base_i,
  input  logic [Depth:0]   count_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] checksum_o,
  output logic             mem_cs_no,
  output logic             mem_oe_o,
  output logic             mem_we_o,
  output logic [Depth-1:0] mem_addr_o,
  output logic [Width-1:0] mem_wdata_o,
  input  logic [Width-1:0] mem_rdata_i
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] TURN  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [Depth:0] CNT_ZERO = '0;
  localparam logic [Depth:0] CNT_ONE  = (Depth+1)'(1);

  logic [2:0]       state_reg;
  logic [Depth:0]   remaining_reg;
  logic [Width-1:0] rdata_reg;
  logic [Width-1:0] scrambled;

  // Interleave low-half bits with mirrored high-half bits, MSB first.
  generate
    for (genvar gi = 0; gi < Width / 2; gi++) begin : g_scramble
      assign scrambled[Width-1-2*gi] = rdata_reg[gi];
      assign scrambled[Width-2-2*gi] = rdata_reg[Width-1-gi];
    end
  endgenerate

  // Bus outputs are registered alongside the state, so each is set for the state being entered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      rdata_reg     <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      checksum_o    <= '0;
      mem_cs_no     <= 1'b1;
      mem_oe_o      <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
    end else begin
      done_o <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            checksum_o    <= '0;
            remaining_reg <= count_i;
            mem_addr_o    <= base_i;
            if (count_i == CNT_ZERO) begin
              state_reg <= DONE;
              done_o    <= 1'b1;
            end else begin
              state_reg <= READ;
              busy_o    <= 1'b1;
              mem_cs_no <= 1'b0;
              mem_oe_o  <= 1'b1;
            end
          end
        end
        READ: begin
          rdata_reg <= mem_rdata_i;
          state_reg <= TURN;
          mem_cs_no <= 1'b1;
          mem_oe_o  <= 1'b0;
        end
        TURN: begin
          mem_wdata_o <= scrambled;
          state_reg   <= WRITE;
          mem_cs_no   <= 1'b0;
          mem_we_o    <= 1'b1;
        end
        WRITE: begin
          checksum_o <= checksum_o ^ mem_wdata_o;
          mem_we_o   <= 1'b0;
          if (remaining_reg > CNT_ONE) begin
            remaining_reg <= remaining_reg - CNT_ONE;
            mem_addr_o    <= mem_addr_o + Depth'(1);
            state_reg     <= READ;
            mem_oe_o      <= 1'b1;
          end else begin
            state_reg <= DONE;
            mem_cs_no <= 1'b1;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_o    <= 1'b0;
          mem_cs_no <= 1'b1;
          mem_oe_o  <= 1'b0;
          mem_we_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_scrambler.sv
// Scoreboard bench for mem_scrambler: a behavioural memory, a bus monitor logging writes,
// and expected writes queued at stimulus time and matched against the log after each pass.
module tb_mem_scrambler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [4:0] base = '0;
  logic [5:0] count = '0;
  logic       busy, done;
  logic [7:0] checksum;
  logic       mem_cs_n, mem_oe, mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;

  logic [7:0] mem [32];
  logic       pl_en = 1'b0;
  logic [4:0] pl_a = '0;
  logic [7:0] pl_d = '0;

  logic [12:0] exp_q [$];
  logic [12:0] wr_log [$];
  int rd_idx = 0;
  int total = 0;
  int bad = 0;
  int busy_cnt = 0, cs_low_cnt = 0, done_cnt = 0, overlap_cnt = 0;

  always #5 clk = ~clk;

  mem_scrambler #(.Width(8), .Depth(5)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .base_i(base), .count_i(count),
    .busy_o(busy), .done_o(done), .checksum_o(checksum),
    .mem_cs_no(mem_cs_n), .mem_oe_o(mem_oe), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  assign mem_rdata = (!mem_cs_n && mem_oe) ? mem[mem_addr] : 8'h00;

  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (!mem_cs_n && mem_we) mem[mem_addr] <= mem_wdata;
  end

  always @(negedge clk) begin
    if (mem_oe && mem_we) overlap_cnt++;
    if (busy) busy_cnt++;
    if (!mem_cs_n) cs_low_cnt++;
    if (done) done_cnt++;
    if (!mem_cs_n && mem_we) wr_log.push_back({mem_addr, mem_wdata});
  end

  function automatic logic [7:0] scr(input logic [7:0] x);
    return {x[0], x[7], x[1], x[6], x[2], x[5], x[3], x[4]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic poke(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic drain();
    while (exp_q.size() > 0) begin
      logic [12:0] e;
      e = exp_q.pop_front();
      if (rd_idx < wr_log.size()) begin
        chk("write addr/data", wr_log[rd_idx], e);
        rd_idx++;
      end else begin
        chk("missing write", 0, e);
      end
    end
    chk("unexpected writes", wr_log.size() - rd_idx, 0);
    rd_idx = wr_log.size();
  endtask

  task automatic do_pass(input logic [4:0] b, input logic [5:0] n, input bit extra, output int dc);
    dc = -1;
    @(negedge clk);
    base = b; count = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 200 && dc < 0; i++) begin
      if (i == 1 && n != 0) begin
        chk("read oe", mem_oe, 1);
        chk("read cs_n", mem_cs_n, 0);
        chk("read addr", mem_addr, b);
      end
      if (done) begin
        dc = i;
        start = extra;
      end else begin
        start = extra && (i == 2);
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (dc < 0) chk("done timeout", 0, 1);
  endtask

  initial begin
    int dc, b0, c0, d0, o0;
    logic [7:0] pre [8];

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst cs_n", mem_cs_n, 1);
    chk("rst oe", mem_oe, 0);
    chk("rst we", mem_we, 0);
    chk("rst addr", mem_addr, 0);
    chk("rst wdata", mem_wdata, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst checksum", checksum, 0);
    c0 = cs_low_cnt;
    repeat (10) @(negedge clk);
    chk("idle cs_n low cycles", cs_low_cnt - c0, 0);

    // single word
    poke(5'h10, 8'hDA);
    expect_wr(5'h10, 8'h73);
    b0 = busy_cnt; d0 = done_cnt; o0 = overlap_cnt;
    do_pass(5'h10, 6'd1, 1'b0, dc);
    chk("single done latency", dc, 4);
    chk("single mem", mem[5'h10], 8'h73);
    chk("single checksum", checksum, 8'h73);
    chk("single busy cycles", busy_cnt - b0, 3);
    chk("single done pulses", done_cnt - d0, 1);
    chk("single oe/we overlap", overlap_cnt - o0, 0);
    drain();

    // block of 4
    poke(5'h04, 8'h01); poke(5'h05, 8'h80); poke(5'h06, 8'hFF); poke(5'h07, 8'h00);
    expect_wr(5'h04, 8'h80); expect_wr(5'h05, 8'h40);
    expect_wr(5'h06, 8'hFF); expect_wr(5'h07, 8'h00);
    b0 = busy_cnt; o0 = overlap_cnt;
    do_pass(5'h04, 6'd4, 1'b0, dc);
    chk("block4 done latency", dc, 13);
    chk("block4 mem4", mem[5'h04], 8'h80);
    chk("block4 mem5", mem[5'h05], 8'h40);
    chk("block4 checksum", checksum, 8'h3F);
    chk("block4 busy cycles", busy_cnt - b0, 12);
    chk("block4 oe/we overlap", overlap_cnt - o0, 0);
    drain();

    // wrap-around
    poke(5'h1E, 8'h01); poke(5'h1F, 8'h80); poke(5'h00, 8'h00); poke(5'h01, 8'hFF);
    poke(5'h02, 8'h5A);
    expect_wr(5'h1E, 8'h80); expect_wr(5'h1F, 8'h40);
    expect_wr(5'h00, 8'h00); expect_wr(5'h01, 8'hFF);
    do_pass(5'h1E, 6'd4, 1'b0, dc);
    chk("wrap done latency", dc, 13);
    chk("wrap mem1F", mem[5'h1F], 8'h40);
    chk("wrap mem02 untouched", mem[5'h02], 8'h5A);
    drain();

    // zero count
    c0 = cs_low_cnt; d0 = done_cnt;
    do_pass(5'h03, 6'd0, 1'b0, dc);
    chk("zero done latency", dc, 1);
    chk("zero cs_n low cycles", cs_low_cnt - c0, 0);
    chk("zero checksum cleared", checksum, 0);
    chk("zero done pulses", done_cnt - d0, 1);
    drain();

    // 2-word pass with ignored starts in TURN and DONE
    poke(5'h14, 8'h0F); poke(5'h15, 8'hF0); poke(5'h16, 8'h33);
    expect_wr(5'h14, scr(8'h0F)); expect_wr(5'h15, scr(8'hF0));
    b0 = busy_cnt;
    do_pass(5'h14, 6'd2, 1'b1, dc);
    repeat (8) @(negedge clk);
    chk("ignored start done latency", dc, 7);
    chk("ignored start busy cycles", busy_cnt - b0, 6);
    chk("ignored start checksum", checksum, 8'hFF);
    chk("ignored start mem16", mem[5'h16], 8'h33);
    drain();

    // reset during third word's TURN
    for (int i = 0; i < 8; i++) begin
      pre[i] = 8'(i * 37 + 5);
      poke(5'(8 + i), pre[i]);
    end
    expect_wr(5'h08, scr(pre[0])); expect_wr(5'h09, scr(pre[1]));
    d0 = done_cnt;
    @(negedge clk);
    base = 5'h08; count = 6'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("midrst in turn", {mem_oe, mem_we, mem_cs_n, busy}, 4'b0011);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst we", mem_we, 0);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst cs_n", mem_cs_n, 1);
    repeat (10) @(negedge clk);
    chk("midrst done pulses", done_cnt - d0, 0);
    chk("midrst mem08", mem[5'h08], scr(pre[0]));
    chk("midrst mem09", mem[5'h09], scr(pre[1]));
    for (int i = 2; i < 8; i++) chk("midrst mem untouched", mem[5'(8 + i)], pre[i]);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
